// File: rtl/debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : debounce_pkg                                              |
// | Purpose  : Shared defaults and width helper for the debounce filter. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package debounce_pkg;

  localparam int c_def_channels    = 2;
  localparam int c_def_stable_cnt  = 26;
  localparam int c_def_prescale    = 1;
  localparam int c_def_sync_stages = 2;

  // Bits needed to hold 0..v-1; never less than one bit so a counter
  // for v=1 still has a legal declaration.
  function automatic int clog2_min1(input int v);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : debounce_chan                                             |
// | Purpose  : One debounce channel: synchroniser, stability counter,    |
// |            registered output level and edge pulses.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT  = c_def_stable_cnt,
  parameter int SYNC_STAGES = c_def_sync_stages
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_inp,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  localparam int              c_cw  = clog2_min1(STABLE_CNT);
  localparam logic [c_cw-1:0] c_max = c_cw'(STABLE_CNT - 1);

  logic            w_sample;
  logic [c_cw-1:0] r_cnt;
  logic            r_out;
  logic            r_rise;
  logic            r_fall;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Shift the raw input through the synchroniser; reset preloads the
      // current level so no spurious difference appears after reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= {SYNC_STAGES{i_inp}};
        end else begin
          r_sync[0] <= i_inp;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end

      assign w_sample = r_sync[SYNC_STAGES-1];
    end else begin : g_nosync
      assign w_sample = i_inp;
    end
  endgenerate

  // Count consecutive differing ticks; commit the new level and pulse
  // the matching edge output only on the tick that completes the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_out  <= i_inp;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_tick) begin
        if (w_sample == r_out) begin
          r_cnt <= '0;
        end else if (r_cnt == c_max) begin
          r_out  <= w_sample;
          r_cnt  <= '0;
          r_rise <= w_sample;
          r_fall <= ~w_sample;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_busy = |r_cnt;

endmodule
`default_nettype wire

// File: rtl/debounce_filter_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : debounce_filter_mc                                        |
// | Purpose  : Multi-channel debounce filter with a shared sample-tick   |
// |            prescaler and independent per-channel filters.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module debounce_filter_mc
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = c_def_channels,
  parameter int STABLE_CNT  = c_def_stable_cnt,
  parameter int PRESCALE    = c_def_prescale,
  parameter int SYNC_STAGES = c_def_sync_stages
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] inp,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] busy
);

  localparam int              c_pw      = clog2_min1(PRESCALE);
  localparam logic [c_pw-1:0] c_pre_max = c_pw'(PRESCALE - 1);

  logic [c_pw-1:0] r_pre;
  logic            w_tick;

  // The tick fires on the last count of each prescale period, and never
  // while the filter is disabled.
  assign w_tick = en & (r_pre == c_pre_max);

  // Free-running prescale counter that freezes whenever en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (en) begin
      if (r_pre == c_pre_max) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      debounce_chan #(
        .STABLE_CNT  (STABLE_CNT),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
        .clk    (clk),
        .rst    (rst),
        .i_tick (w_tick),
        .i_inp  (inp[g]),
        .o_out  (out[g]),
        .o_rise (rise[g]),
        .o_fall (fall[g]),
        .o_busy (busy[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_filter_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_debounce_filter_mc                                     |
// | Purpose  : Directed, table-driven bench for debounce_filter_mc.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_debounce_filter_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en;
  logic [1:0] inp_a, out_a, rise_a, fall_a, busy_a;
  logic [1:0] inp_b, out_b, rise_b, fall_b, busy_b;
  logic [0:0] inp_c, out_c, rise_c, fall_c, busy_c;

  // A: STABLE_CNT=4, PRESCALE=1, SYNC_STAGES=2
  debounce_filter_mc #(.CHANNELS(2), .STABLE_CNT(4), .PRESCALE(1), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .inp(inp_a),
    .out(out_a), .rise(rise_a), .fall(fall_a), .busy(busy_a));

  // B: PRESCALE=3
  debounce_filter_mc #(.CHANNELS(2), .STABLE_CNT(4), .PRESCALE(3), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .inp(inp_b),
    .out(out_b), .rise(rise_b), .fall(fall_b), .busy(busy_b));

  // C: STABLE_CNT=1, no synchroniser -> out follows inp each clock
  debounce_filter_mc #(.CHANNELS(1), .STABLE_CNT(1), .PRESCALE(1), .SYNC_STAGES(0)) u_dut_c (
    .clk(clk), .rst(rst), .en(en), .inp(inp_c),
    .out(out_c), .rise(rise_c), .fall(fall_c), .busy(busy_c));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [1:0] inp;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] busy;
  } vec_t;

  vec_t tbl [34];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic r, input logic e, input logic [1:0] ia,
                      input logic [1:0] ib, input logic ic);
    @(negedge clk);
    rst   = r;
    en    = e;
    inp_a = ia;
    inp_b = ib;
    inp_c = ic;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pk_a();
    return {out_a, rise_a, fall_a, busy_a};
  endfunction

  initial begin
    int   lat;
    logic prev_c;
    logic seq_c [6];

    rst = 1'b1; en = 1'b1; inp_a = 2'b10; inp_b = 2'b10; inp_c = 1'b0;

    //             rst   en    inp    out    rise   fall   busy
    tbl[0]  = '{1'b1, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    // held change on ch0: commit on the 6th edge
    tbl[2]  = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[3]  = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[5]  = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[6]  = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[7]  = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    tbl[8]  = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    // held change back to 0: fall pulse
    tbl[9]  = '{1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
    tbl[12] = '{1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
    tbl[13] = '{1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
    tbl[14] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
    tbl[15] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    // 3-clock glitch: rejected
    tbl[16] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[17] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[18] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[19] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[20] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[21] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[22] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    // 4-clock pulse: accepted, then debounced back to 0
    tbl[23] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[24] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[25] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[26] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[27] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
    tbl[28] = '{1'b0, 1'b1, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
    tbl[29] = '{1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
    tbl[30] = '{1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
    tbl[31] = '{1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01};
    tbl[32] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
    tbl[33] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};

    for (int i = 0; i < 34; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].inp, 2'b10, 1'b0);
      check($sformatf("vec%0d", i), pk_a(),
            {tbl[i].out, tbl[i].rise, tbl[i].fall, tbl[i].busy});
    end

    // Enable freeze mid-count: reach counter=2, hold 10 clocks disabled.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b11, 2'b10, 1'b0);
    check("en_pre_busy", pk_a(), {2'b10, 2'b00, 2'b00, 2'b01});
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 2'b11, 2'b10, 1'b0);
      check($sformatf("en_frozen%0d", i), pk_a(), {2'b10, 2'b00, 2'b00, 2'b01});
    end
    step(1'b0, 1'b1, 2'b11, 2'b10, 1'b0);
    check("en_resume1", pk_a(), {2'b10, 2'b00, 2'b00, 2'b01});
    step(1'b0, 1'b1, 2'b11, 2'b10, 1'b0);
    check("en_resume2", pk_a(), {2'b11, 2'b01, 2'b00, 2'b00});
    step(1'b0, 1'b1, 2'b11, 2'b10, 1'b0);
    check("en_resume3", pk_a(), {2'b11, 2'b00, 2'b00, 2'b00});

    // Reset mid-count: out loads inp directly, no rise now or next cycle.
    step(1'b1, 1'b1, 2'b10, 2'b10, 1'b0);
    check("rst_to_10", pk_a(), {2'b10, 2'b00, 2'b00, 2'b00});
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b11, 2'b10, 1'b0);
    check("rst_cnt2", pk_a(), {2'b10, 2'b00, 2'b00, 2'b01});
    step(1'b1, 1'b1, 2'b11, 2'b10, 1'b0);
    check("rst_mid", pk_a(), {2'b11, 2'b00, 2'b00, 2'b00});
    step(1'b0, 1'b1, 2'b11, 2'b10, 1'b0);
    check("rst_after", pk_a(), {2'b11, 2'b00, 2'b00, 2'b00});

    // Prescaler: count edges from the input change to the out change.
    lat = 99;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 1'b1, 2'b11, 2'b11, 1'b0);
      if (out_b[0] === 1'b1) begin
        lat = i;
        check("presc_rise", {6'b0, rise_b}, 8'h01);
        break;
      end
      check($sformatf("presc_hold%0d", i), {4'b0, out_b, rise_b}, 8'h08);
    end
    check("presc_latency_ok", {7'b0, (lat >= 12 && lat <= 14)}, 8'h01);
    step(1'b0, 1'b1, 2'b11, 2'b11, 1'b0);
    check("presc_after", {4'b0, out_b, rise_b}, 8'h0C);

    // STABLE_CNT=1, no synchroniser: out tracks inp on every clock.
    seq_c[0] = 1'b1; seq_c[1] = 1'b1; seq_c[2] = 1'b0;
    seq_c[3] = 1'b1; seq_c[4] = 1'b0; seq_c[5] = 1'b0;
    prev_c = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 2'b11, 2'b11, seq_c[i]);
      check($sformatf("c_follow%0d", i), {4'b0, out_c, rise_c, fall_c, busy_c},
            {4'b0, seq_c[i], seq_c[i] & ~prev_c, ~seq_c[i] & prev_c, 1'b0});
      prev_c = seq_c[i];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire
